regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (wen/wregn/wdata) between NREQ writeback

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_if
// Purpose : Writeback request, scoreboard and regfile write-port bundle.
// Rev     : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_regn;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               rsv_en;
  logic [4:0]         rsv_regn;
  logic [31:0]        busy;
  logic               wen;
  logic [4:0]         wregn;
  logic [31:0]        wdata;
  logic [IDW-1:0]     gnt_id;

  modport master (
    output req_valid, req_regn, req_data, stall, rsv_en, rsv_regn,
    input  req_ready, busy, wen, wregn, wdata, gnt_id
  );

  modport slave (
    input  req_valid, req_regn, req_data, stall, rsv_en, rsv_regn,
    output req_ready, busy, wen, wregn, wdata, gnt_id
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Purpose : Arbitrates NREQ writeback sources onto one registered regfile
//           write port and tracks pending writes in a 32-entry scoreboard.
//           Define WB_ARB_RR_EN for round-robin; default is fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);

  logic [4:0]     regn_a [NREQ];
  logic [31:0]    data_a [NREQ];
  logic [IDW-1:0] win;
  logic           xfer;
  logic [4:0]     sel_regn;
  logic [31:0]    sel_data;

  logic           wen_q;
  logic [4:0]     wregn_q;
  logic [31:0]    wdata_q;
  logic [IDW-1:0] gnt_q;
  logic [31:0]    busy_q, busy_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign regn_a[i] = bus.req_regn[5*i +: 5];
    assign data_a[i] = bus.req_data[32*i +: 32];
  end

`ifdef WB_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  int             idx;

  // Descending scan so the lowest offset from rr_ptr is assigned last and wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) win = IDW'(idx);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) win = IDW'(k);
    end
  end
`endif

  assign xfer     = (|bus.req_valid) && !bus.stall && !reset;
  assign sel_regn = regn_a[win];
  assign sel_data = data_a[win];

  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[win] = xfer;
  end

  // A same-cycle reservation overrides the clear from a completing write.
  always_comb begin
    busy_d = busy_q;
    if (xfer)       busy_d[sel_regn]     = 1'b0;
    if (bus.rsv_en) busy_d[bus.rsv_regn] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      wregn_q <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      wen_q  <= xfer && (sel_regn != 5'd0);
      busy_q <= busy_d;
      if (xfer) begin
        wregn_q <= sel_regn;
        wdata_q <= sel_data;
        gnt_q   <= win;
      end
    end
  end

  assign bus.wen    = wen_q;
  assign bus.wregn  = wregn_q;
  assign bus.wdata  = wdata_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Purpose : Self-checking bench for regfile_wb_arbiter (NREQ=3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  regfile_wb_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [14:0] regn;
    logic [31:0] d;
    logic        stall;
    logic        rsv_en;
    logic [4:0]  rsv_regn;
    logic [2:0]  e_rdy;
    logic        e_wen;
    logic [4:0]  e_wregn;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  wregn;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [31:0] busy;
  } out_t;

  int n_chk = 0;
  int n_err = 0;
  vec_t vt[$];
  out_t sbq[$];

  logic        m_wen;
  logic [4:0]  m_wregn;
  logic [31:0] m_wdata;
  logic [1:0]  m_gnt;
  logic [31:0] m_busy;
  int          m_rr;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] valid, input logic [4:0] r0,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] d,
                              input logic stall, input logic rsv_en, input logic [4:0] rsv_regn,
                              input logic [2:0] e_rdy, input logic e_wen, input logic [4:0] e_wregn,
                              input logic [31:0] e_busy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.regn = {r2, r1, r0}; v.d = d; v.stall = stall;
    v.rsv_en = rsv_en; v.rsv_regn = rsv_regn; v.e_rdy = e_rdy; v.e_wen = e_wen;
    v.e_wregn = e_wregn; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic int pick(input logic [2:0] v);
`ifdef WB_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      if (v[(m_rr + k) % 3]) return (m_rr + k) % 3;
    end
`else
    for (int j = 0; j < 3; j++) begin
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    bus.req_valid = v.valid;
    bus.req_regn  = v.regn;
    for (int i = 0; i < 3; i++) bus.req_data[32*i +: 32] = v.d ^ (32'(i) << 28);
    bus.stall     = v.stall;
    bus.rsv_en    = v.rsv_en;
    bus.rsv_regn  = v.rsv_regn;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag, output int g);
    logic [2:0] er;
    logic [4:0] rn;
    out_t       e;
    #1;
    g = -1;
    if (!reset && !bus.stall) g = pick(bus.req_valid);
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk(tag, "ready", 32'(bus.req_ready), 32'(er));
    if (reset) begin
      m_wen = 1'b0; m_wregn = '0; m_wdata = '0; m_gnt = '0; m_busy = '0; m_rr = 0;
    end else begin
      m_wen = 1'b0;
      if (g >= 0) begin
        rn      = bus.req_regn[5*g +: 5];
        m_wen   = (rn != 5'd0);
        m_wregn = rn;
        m_wdata = bus.req_data[32*g +: 32];
        m_gnt   = 2'(g);
        m_rr    = (g + 1) % 3;
        if (rn != 5'd0) m_busy[rn] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_regn != 5'd0) m_busy[bus.rsv_regn] = 1'b1;
    end
    sbq.push_back('{m_wen, m_wregn, m_wdata, m_gnt, m_busy});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(tag, "wen",    32'(bus.wen),    32'(e.wen));
    chk(tag, "wregn",  32'(bus.wregn),  32'(e.wregn));
    chk(tag, "wdata",  bus.wdata,       e.wdata);
    chk(tag, "gnt_id", 32'(bus.gnt_id), 32'(e.gnt));
    chk(tag, "busy",   bus.busy,        e.busy);
    @(negedge clk);
  endtask

  initial begin
    int          g;
    logic [1:0]  exp_gnt [3];
    logic [2:0]  rv;
    logic [14:0] rg;
    logic [95:0] rd;
    string       tag;

    reset = 1'b1;
    bus.req_valid = '0; bus.req_regn = '0; bus.req_data = '0;
    bus.stall = 1'b0; bus.rsv_en = 1'b0; bus.rsv_regn = '0;
    m_rr = 0;

    //            rst valid r0 r1 r2 data          stl rsv rreg rdy   wen wregn busy
    vt.push_back(mk(1, 3'b001, 3, 0, 0, 32'h1111_0000, 0, 1, 3, 3'b000, 0, 0, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 0, 3'b000, 0, 0, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 0, 3'b000, 0, 0, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 0, 3'b000, 0, 0, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 1, 2, 3'b000, 0, 0, 32'h4));
    vt.push_back(mk(0, 3'b001, 2, 0, 0, 32'hABCD_1234, 0, 0, 0, 3'b001, 1, 2, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 1, 7, 3'b000, 0, 2, 32'h80));
    vt.push_back(mk(0, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 3'b010, 0, 0, 32'h80));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 1, 5, 3'b000, 0, 0, 32'hA0));
    vt.push_back(mk(0, 3'b100, 0, 0, 5, 32'h5555_0005, 0, 1, 5, 3'b100, 1, 5, 32'hA0));
    vt.push_back(mk(0, 3'b100, 0, 0, 7, 32'h7777_0007, 0, 0, 0, 3'b100, 1, 7, 32'h20));
    vt.push_back(mk(0, 3'b100, 0, 0, 5, 32'h5A5A_0005, 0, 0, 0, 3'b100, 1, 5, 32'h0));
    vt.push_back(mk(0, 3'b001, 9, 0, 0, 32'h9999_0009, 1, 1, 4, 3'b000, 0, 5, 32'h10));
    vt.push_back(mk(0, 3'b001, 9, 0, 0, 32'h9999_0009, 1, 0, 0, 3'b000, 0, 5, 32'h10));
    vt.push_back(mk(0, 3'b001, 9, 0, 0, 32'h9999_0009, 0, 0, 0, 3'b001, 1, 9, 32'h10));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 1, 0, 3'b000, 0, 9, 32'h10));
    vt.push_back(mk(0, 3'b001, 4, 0, 0, 32'h4444_0004, 0, 1, 4, 3'b001, 1, 4, 32'h10));
    vt.push_back(mk(1, 3'b010, 0, 6, 0, 32'h6666_0006, 0, 1, 3, 3'b000, 0, 0, 32'h0));
    vt.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 0, 3'b000, 0, 0, 32'h0));

    @(negedge clk);
    for (int k = 0; k < vt.size(); k++) begin
      tag = $sformatf("vec%0d", k);
      drive(vt[k]);
      #1;
      chk(tag, "tbl_ready", 32'(bus.req_ready), 32'(vt[k].e_rdy));
      step(tag, g);
      chk(tag, "tbl_wen",   32'(bus.wen),   32'(vt[k].e_wen));
      chk(tag, "tbl_wregn", 32'(bus.wregn), 32'(vt[k].e_wregn));
      chk(tag, "tbl_busy",  bus.busy,       vt[k].e_busy);
    end

    // All three requesters held valid for three cycles.
`ifdef WB_ARB_RR_EN
    exp_gnt[0] = 2'd0; exp_gnt[1] = 2'd1; exp_gnt[2] = 2'd2;
`else
    exp_gnt[0] = 2'd0; exp_gnt[1] = 2'd0; exp_gnt[2] = 2'd0;
`endif
    drive(mk(0, 3'b111, 8, 9, 10, 32'h3000_0000, 0, 0, 0, 3'b000, 0, 0, 32'h0));
    for (int j = 0; j < 3; j++) begin
      step($sformatf("all3_%0d", j), g);
      chk($sformatf("all3_%0d", j), "order", 32'(bus.gnt_id), 32'(exp_gnt[j]));
      chk($sformatf("all3_%0d", j), "wen1", 32'(bus.wen), 32'h1);
    end

    // Random traffic honouring the hold-until-accepted rule.
    rv = '0; rg = '0; rd = '0; g = -1;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] || g == i) begin
          rv[i]          = 1'($urandom_range(0, 1));
          rg[5*i +: 5]   = 5'($urandom_range(0, 31));
          rd[32*i +: 32] = $urandom;
        end
      end
      reset         = 1'b0;
      bus.req_valid = rv;
      bus.req_regn  = rg;
      bus.req_data  = rd;
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.rsv_en    = 1'($urandom_range(0, 1));
      bus.rsv_regn  = 5'($urandom_range(0, 31));
      step($sformatf("rnd%0d", c), g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
